// File: rtl/otp_lc_macro_rsp.sv
// -----------------------------------------------------------------------------
// otp_lc_macro_rsp
//
// Responder end of the OTP macro command interface for the life cycle partition
// window. Accepts single-word Read/Write commands over req/gnt, answers each one
// RspLatency cycles after the grant with a one-cycle rvalid strobe and an error
// code. The window is a write-once word array with OTP blank-check semantics:
// a write may only turn bits from 0 to 1.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   otp_req_i       command request, held until granted
//   otp_cmd_i       command code (only Read and Write are legal)
//   otp_size_i      native words minus one (only 0 is legal)
//   otp_wdata_i     write data (low OtpWidth bits used)
//   otp_addr_i      halfword address
//   err_inj_i       force MacroEccCorrError on this command (optional)
//   otp_gnt_o       command accepted (combinational from otp_req_i when idle)
//   otp_rvalid_o    one-cycle response strobe
//   otp_rdata_o     read data, zero-extended
//   otp_err_o       response code
//   busy_o          a command is outstanding
//
// Configuration:
//   OTP_LC_RSP_ERR_INJ_EN  when defined, adds err_inj_i. A command granted with
//                          err_inj_i high answers MacroEccCorrError unless an
//                          illegal-command or blank-check error takes priority;
//                          writes still update the array and reads still
//                          return data.
// -----------------------------------------------------------------------------
module otp_lc_macro_rsp #(
   parameter int                      OtpAddrWidth     = 10,
   parameter int                      OtpWidth         = 16,
   parameter int                      NumWords         = 44,
   parameter logic [OtpAddrWidth-1:0] BaseAddr         = 10'h3D0,
   parameter int                      RspLatency       = 2,   // legal range 1..7
   parameter int                      OtpSizeWidth     = 2,
   parameter int                      OtpIfWidth       = 64,
   parameter int                      ScrmblBlockWidth = 64,
   parameter int                      CmdWidth         = 7,
   parameter int                      ErrWidth         = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        otp_req_i,
   input  logic [CmdWidth-1:0]         otp_cmd_i,
   input  logic [OtpSizeWidth-1:0]     otp_size_i,
   input  logic [OtpIfWidth-1:0]       otp_wdata_i,
   input  logic [OtpAddrWidth-1:0]     otp_addr_i,
`ifdef OTP_LC_RSP_ERR_INJ_EN
   input  logic                        err_inj_i,
`endif
   output logic                        otp_gnt_o,
   output logic                        otp_rvalid_o,
   output logic [ScrmblBlockWidth-1:0] otp_rdata_o,
   output logic [ErrWidth-1:0]         otp_err_o,
   output logic                        busy_o
);

   // Command and error encodings of the OTP macro interface.
   localparam logic [CmdWidth-1:0] CmdRead  = 7'b1000101;
   localparam logic [CmdWidth-1:0] CmdWrite = 7'b0110111;

   localparam logic [ErrWidth-1:0] NoError              = 3'h0;
   localparam logic [ErrWidth-1:0] MacroError           = 3'h1;
   localparam logic [ErrWidth-1:0] MacroEccCorrError    = 3'h2;
   localparam logic [ErrWidth-1:0] MacroWriteBlankError = 3'h4;

   localparam int                  IdxWidth = $clog2(NumWords);
   localparam logic [2:0]          LatLoad  = 3'(RspLatency - 1);
   // One bit wider than the address so the top of the window cannot wrap.
   localparam logic [OtpAddrWidth:0] LastAddr =
      (OtpAddrWidth + 1)'(int'(BaseAddr) + NumWords - 1);

   typedef enum logic [1:0] {
      IdleSt = 2'b00,
      WaitSt = 2'b01,
      RspSt  = 2'b10
   } state_e;

   state_e                    state_q, state_d;
   logic [2:0]                cnt_q, cnt_d;
   logic [CmdWidth-1:0]       cmd_q, cmd_d;
   logic [OtpSizeWidth-1:0]   size_q, size_d;
   logic [OtpAddrWidth-1:0]   addr_q, addr_d;
   logic [OtpWidth-1:0]       wdata_q, wdata_d;
   logic                      inj_q, inj_d;
   logic                      fault_q, fault_d;  // sticky: FSM left its legal states
   logic [OtpWidth-1:0]       mem_q [NumWords];
   logic [OtpWidth-1:0]       mem_d [NumWords];

   logic                      err_inj;
   logic                      in_window;
   logic                      cmd_illegal;
   logic [OtpAddrWidth-1:0]   idx_full;
   logic [IdxWidth-1:0]       idx;
   logic                      unused_bits;

`ifdef OTP_LC_RSP_ERR_INJ_EN
   assign err_inj = err_inj_i;
`else
   assign err_inj = 1'b0;
`endif

   // The range check runs on the raw address; the subtraction is only
   // meaningful once the address is known to be inside the window.
   assign in_window   = (addr_q >= BaseAddr) && ({1'b0, addr_q} <= LastAddr);
   assign idx_full    = addr_q - BaseAddr;
   assign idx         = idx_full[IdxWidth-1:0];
   assign cmd_illegal = fault_q || !((cmd_q == CmdRead) || (cmd_q == CmdWrite)) ||
                        (size_q != '0) || !in_window;
   assign busy_o      = (state_q != IdleSt);

   assign unused_bits = ^{otp_wdata_i[OtpIfWidth-1:OtpWidth],
                          idx_full[OtpAddrWidth-1:IdxWidth]};

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      cmd_d        = cmd_q;
      size_d       = size_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      inj_d        = inj_q;
      fault_d      = fault_q;
      mem_d        = mem_q;
      otp_gnt_o    = 1'b0;
      otp_rvalid_o = 1'b0;
      otp_rdata_o  = '0;
      otp_err_o    = NoError;

      case (state_q)
         IdleSt: begin
            otp_gnt_o = otp_req_i;
            if (otp_req_i) begin
               cmd_d   = otp_cmd_i;
               size_d  = otp_size_i;
               addr_d  = otp_addr_i;
               wdata_d = otp_wdata_i[OtpWidth-1:0];
               inj_d   = err_inj;
               cnt_d   = LatLoad;
               if (RspLatency == 1) state_d = RspSt;
               else                 state_d = WaitSt;
            end
         end
         WaitSt: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_d == 3'd0) state_d = RspSt;
         end
         RspSt: begin
            otp_rvalid_o = 1'b1;
            state_d      = IdleSt;
            if (cmd_illegal) begin
               otp_err_o = MacroError;
            end else if ((cmd_q == CmdWrite) && ((mem_q[idx] & ~wdata_q) != '0)) begin
               otp_err_o = MacroWriteBlankError;
            end else begin
               if (cmd_q == CmdWrite) begin
                  mem_d[idx] = mem_q[idx] | wdata_q;
               end else begin
                  otp_rdata_o = {{(ScrmblBlockWidth - OtpWidth){1'b0}}, mem_q[idx]};
               end
               otp_err_o = inj_q ? MacroEccCorrError : NoError;
            end
         end
         default: begin
            state_d = IdleSt;
            fault_d = 1'b1;
         end
      endcase
   end

   // NOTE: state is updated only with non-blocking assignments so every flop
   // samples its _d value from the same edge regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IdleSt;
         cnt_q   <= '0;
         cmd_q   <= '0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         inj_q   <= 1'b0;
         fault_q <= 1'b0;
         // NOTE: the array must read blank after every reset, so it is built
         // from resettable flops rather than a RAM macro.
         for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         inj_q   <= inj_d;
         fault_q <= fault_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: doc/otp_lc_macro_rsp.md
Name: otp_lc_macro_rsp

Overview:
- Responder end of the OTP macro command interface, for the life cycle partition window.
- Accepts the 16-bit program/read commands an LC write initiator issues (req/gnt, then rvalid with error code).
- Holds a write-once word array with OTP blank-check semantics: bits can only go 0->1.
- Serves as the macro-side model and as the lightweight LC-window macro adapter in reduced configurations.

Parameters:
- NumWords, 44, number of 16-bit words in the LC window (LC partition size / 2).
- BaseAddr, 10'h3D0, first halfword address of the window; addresses outside [BaseAddr, BaseAddr+NumWords-1] are rejected.
- RspLatency, 2, cycles from grant to rvalid; legal range 1..7.
- OtpWidth, 16, native word width.
- OtpAddrWidth, 10, halfword address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- otp_req_i  in  1  command request, held until granted
- otp_cmd_i  in  prim_otp_pkg::cmd_e  Read or Write; any other value is illegal
- otp_size_i  in  OtpSizeWidth  native words minus one; only 0 is supported
- otp_wdata_i  in  OtpIfWidth  write data; low OtpWidth bits are used
- otp_addr_i  in  OtpAddrWidth  halfword address
- otp_gnt_o  out  1  command accepted
- otp_rvalid_o  out  1  one-cycle response strobe
- otp_rdata_o  out  ScrmblBlockWidth  read data, zero-extended
- otp_err_o  out  prim_otp_pkg::err_e  response code
- busy_o  out  1  a command is outstanding

Behaviour:
- Reset:
  - All outputs are 0 and otp_err_o = NoError.
  - Word array is cleared to 0 (blank).
  - FSM is in IdleSt.
- States: IdleSt, WaitSt, RspSt. Any other encoding -> IdleSt with MacroError on the next accepted command (sticky flag, cleared by reset).
- IdleSt:
  - otp_gnt_o = otp_req_i, combinationally, in the same cycle.
  - On grant: capture cmd, size, addr and wdata[15:0]; load the latency counter with RspLatency-1; go to WaitSt, or straight to RspSt when RspLatency = 1.
- WaitSt: decrement the counter; on 0 go to RspSt. otp_gnt_o = 0 while busy, so requests stall.
- RspSt: otp_rvalid_o = 1 for exactly one cycle, then IdleSt. The next grant is possible in the cycle after rvalid, giving a minimum period of RspLatency+1 cycles per command.
- Response evaluation uses captured values and is performed in RspSt, in this priority order:
  1. Illegal cmd, size != 0, or address out of window -> MacroError; array unchanged; rdata = 0.
  2. Write with (mem[idx] & ~wdata) != 0 -> MacroWriteBlankError; array unchanged.
  3. Write otherwise -> mem[idx] <= mem[idx] | wdata; NoError.
  4. Read -> rdata = {48'b0, mem[idx]}; NoError.
- Index: idx = addr - BaseAddr, computed at OtpAddrWidth width; the range check is done before the subtraction.
- Outside RspSt: otp_rdata_o and otp_err_o are 0/NoError.
- busy_o = (state != IdleSt).
- Boundary conditions:
  - Writing 0 to a blank word succeeds with no change.
  - Rewriting identical data succeeds.
  - addr = BaseAddr+NumWords-1 is legal; addr = BaseAddr+NumWords gives MacroError.
  - Reset asserted mid-command aborts it: no rvalid, array cleared.
  - Request deasserted while in WaitSt has no effect on the outstanding command.

Optional Feature:
- OTP_LC_RSP_ERR_INJ_EN defined:
  - Adds input err_inj_i (1 bit).
  - If err_inj_i is high in the grant cycle, the response is forced to MacroEccCorrError. For a write, the array is still updated normally; for a read, the data is still returned.
  - Illegal-command and blank-check errors take priority over the injected error.
- Undefined: the port is absent and no injected errors are possible.

Test Plan:
- Write addr=BaseAddr, wdata=16'h00A5 after reset -> gnt in the same cycle, rvalid exactly 2 cycles later, err=NoError; a read of the same address returns rdata=64'h00A5.
- Write 16'h00A5 then 16'h00A4 to the same address -> second response MacroWriteBlankError; read still returns 16'h00A5.
- Write 16'h00A5 then 16'h00FF -> NoError; read returns 16'h00FF.
- 44 back-to-back writes over BaseAddr..BaseAddr+43 with req held -> each granted one cycle after the previous rvalid, all NoError; a write to BaseAddr+44 -> MacroError.
- size=1, or cmd=ReadRaw -> MacroError with rdata=0; reset pulsed in WaitSt -> no rvalid, then reads of all words return 0.
- With OTP_LC_RSP_ERR_INJ_EN, write 16'h0003 with err_inj_i=1 -> MacroEccCorrError and a subsequent read returns 16'h0003.
